mem_arbiter_ctrl: RTL

//  Responder side of the CPU memory request interface: services instruction fetches
//  (iREN) and data loads/stores (dREN/dWEN) from one single-port word RAM. The CPU

---
 rtl/mem_arbiter_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter_ctrl.sv
// Memory arbiter: serves data and instruction requests from one single-port RAM.
// Data has fixed priority over fetch; every access is followed by one idle cycle.
module mem_arbiter_ctrl #(
    parameter int LAT = 2,
    parameter int AW  = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic          iwait,
    output logic [31:0]   iload,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [31:0]   dstore,
    output logic          dwait,
    output logic [31:0]   dload,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [31:0]   ramstore,
    input  logic [31:0]   ramload
);

    localparam int CW = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DACC,
        IACC
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_data;
    logic          lat_wr;

    logic d_req;
    logic d_own;
    logic i_own;
    logic done;
    logic d_match;
    logic i_match;
    logic d_fin;
    logic i_fin;
    logic active;

    assign d_req = dREN | dWEN;
    assign d_own = (state == DACC);
    assign i_own = (state == IACC);
    assign done  = (cnt == '0);

    // A store also requires the write data to be unchanged.
    assign d_match = d_req && (daddr == lat_addr) && (dWEN == lat_wr)
                     && (!dWEN || (dstore == lat_data));
    assign i_match = iREN && (iaddr == lat_addr);

    assign d_fin = d_own && done && d_match;
    assign i_fin = i_own && done && i_match;

    assign dwait = d_req & ~d_fin;
    assign iwait = iREN & ~i_fin;
    assign dload = d_fin ? ramload : 32'h0;
    assign iload = i_fin ? ramload : 32'h0;

    assign active   = (d_own && d_req) || (i_own && iREN);
    assign ramREN   = active & ~lat_wr;
    assign ramWEN   = active & lat_wr;
    assign ramaddr  = {lat_addr[AW-1:2], 2'b00};
    assign ramstore = lat_data;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (d_req) begin
                        state    <= DACC;
                        lat_addr <= daddr;
                        lat_data <= dstore;
                        lat_wr   <= dWEN;
                        cnt      <= CW'(LAT - 1);
                    end else if (iREN) begin
                        state    <= IACC;
                        lat_addr <= iaddr;
                        lat_wr   <= 1'b0;
                        cnt      <= CW'(LAT - 1);
                    end
                end
                DACC: begin
                    if (!d_req) begin
                        state <= IDLE;
                    end else if (!d_match) begin
                        lat_addr <= daddr;
                        lat_data <= dstore;
                        lat_wr   <= dWEN;
                        cnt      <= CW'(LAT - 1);
                    end else if (done) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IACC: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (!i_match) begin
                        lat_addr <= iaddr;
                        cnt      <= CW'(LAT - 1);
                    end else if (done) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
